rx_descrambler: RTL and testbench



---
 rtl/pcs_pkg.sv | 25 ++
 rtl/rx_descrambler.sv | 102 ++++++++++
 tb/tb_rx_descrambler.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/pcs_pkg.sv
// Shared 64b/66b PCS constants and types used by the scrambler/descrambler pair.
// Both ends start from the same all-ones LFSR state.
package pcs_pkg;

  localparam int LFSR_WIDTH = 58;
  localparam int TAP_A      = 38;
  localparam int TAP_B      = 57;

  localparam logic [1:0] SYNC_DATA = 2'b01;
  localparam logic [1:0] SYNC_CTRL = 2'b10;

  localparam logic [LFSR_WIDTH-1:0] LFSR_INIT = {LFSR_WIDTH{1'b1}};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WARMUP = 2'd1,
    SYNCED = 2'd2
  } desc_state_e;

  // Only 01 (data) and 10 (control) are legal sync headers.
  function automatic logic hdr_is_bad(input logic [1:0] hdr);
    return (hdr != SYNC_DATA) && (hdr != SYNC_CTRL);
  endfunction

endpackage

// File: rtl/rx_descrambler.sv
// Self-synchronizing 1 + x^39 + x^58 descrambler for the 64b/66b receive path.
// Sync headers ride alongside the payload; o_synced marks words from a flushed LFSR.
module rx_descrambler
  import pcs_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_data_valid,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_hdr_valid,
  input  logic [1:0]            i_hdr,
  input  logic                  i_block_lock,
  output logic                  o_data_valid,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_hdr_valid,
  output logic [1:0]            o_hdr,
  output logic                  o_hdr_err,
  output logic                  o_synced
);

  localparam int         WARMUP_WORDS = (LFSR_WIDTH + DATA_WIDTH - 1) / DATA_WIDTH;
  localparam logic [1:0] WARMUP_CNT   = 2'(WARMUP_WORDS);

  desc_state_e           state_r;
  logic [1:0]            word_cnt_r;
  logic [LFSR_WIDTH-1:0] lfsr_r;
  logic [LFSR_WIDTH-1:0] lfsr_next_s;
  logic [DATA_WIDTH-1:0] descr_s;
  logic [1:0]            cnt_inc_s;
  logic                  hdr_take_s;

  // Bit-serial descramble, LSB first; the LFSR absorbs the received scrambled bits.
  always_comb begin
    lfsr_next_s = lfsr_r;
    descr_s     = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      descr_s[i]  = i_data[i] ^ lfsr_next_s[TAP_A] ^ lfsr_next_s[TAP_B];
      lfsr_next_s = {lfsr_next_s[LFSR_WIDTH-2:0], i_data[i]};
    end
  end

  // In IDLE the counter is 0, so a valid word on the lock-high cycle becomes warm-up word 1.
  assign cnt_inc_s  = word_cnt_r + {1'b0, i_data_valid};
  assign hdr_take_s = i_data_valid & i_hdr_valid;

  // Lock FSM, LFSR state and all output registers.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_r      <= IDLE;
      word_cnt_r   <= 2'd0;
      lfsr_r       <= LFSR_INIT;
      o_data_valid <= 1'b0;
      o_data       <= '0;
      o_hdr_valid  <= 1'b0;
      o_hdr        <= 2'b00;
      o_hdr_err    <= 1'b0;
      o_synced     <= 1'b0;
    end else begin
      o_data_valid <= i_data_valid;
      o_hdr_valid  <= hdr_take_s;
      o_hdr_err    <= hdr_take_s & hdr_is_bad(i_hdr);
      o_synced     <= i_data_valid & i_block_lock & (state_r == SYNCED);

      if (i_data_valid) begin
        lfsr_r <= lfsr_next_s;
        o_data <= descr_s;
      end else begin
        lfsr_r <= lfsr_r;
        o_data <= o_data;
      end

      if (hdr_take_s) begin
        o_hdr <= i_hdr;
      end else begin
        o_hdr <= o_hdr;
      end

      if (!i_block_lock) begin
        state_r    <= IDLE;
        word_cnt_r <= 2'd0;
      end else begin
        case (state_r)
          IDLE, WARMUP: begin
            word_cnt_r <= cnt_inc_s;
            state_r    <= (cnt_inc_s >= WARMUP_CNT) ? SYNCED : WARMUP;
          end
          SYNCED: begin
            state_r    <= SYNCED;
            word_cnt_r <= word_cnt_r;
          end
          default: begin
            state_r    <= IDLE;
            word_cnt_r <= 2'd0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rx_descrambler.sv
// Directed/looped bench for rx_descrambler: a TX scrambler model feeds the DUT and a
// scoreboard queue holds expected words, headers and sync flags until the DUT emits them.
module tb_rx_descrambler;
  import pcs_pkg::*;

  localparam int DW = 32;
  localparam int WW = (58 + DW - 1) / DW;

  logic          clk = 1'b0;
  logic          reset_n, data_valid, hdr_valid, block_lock;
  logic [DW-1:0] data;
  logic [1:0]    hdr;
  logic          o_data_valid, o_hdr_valid, o_hdr_err, o_synced;
  logic [DW-1:0] o_data;
  logic [1:0]    o_hdr;

  always #5 clk = ~clk;

  rx_descrambler #(.DATA_WIDTH(DW)) dut (
    .i_clk(clk), .i_reset_n(reset_n), .i_data_valid(data_valid), .i_data(data),
    .i_hdr_valid(hdr_valid), .i_hdr(hdr), .i_block_lock(block_lock),
    .o_data_valid(o_data_valid), .o_data(o_data), .o_hdr_valid(o_hdr_valid),
    .o_hdr(o_hdr), .o_hdr_err(o_hdr_err), .o_synced(o_synced)
  );

  typedef struct {
    logic [DW-1:0] dmodel;
    logic [DW-1:0] plain;
    bit            plain_ok;
    bit            hv;
    logic [1:0]    h;
    bit            he;
    bit            sy;
  } exp_t;

  exp_t          sb[$];
  int            n_cmp = 0;
  int            n_err = 0;
  logic [57:0]   tx_st;
  logic [57:0]   rx_hist;
  int            cnt;
  bit            loopback;
  logic [DW-1:0] last_data;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Transmit-side scrambler: state holds the last 58 scrambled bits sent.
  function automatic logic [DW-1:0] tx_scramble(input logic [DW-1:0] p);
    logic [DW-1:0] o;
    for (int i = 0; i < DW; i++) begin
      o[i]  = p[i] ^ tx_st[38] ^ tx_st[57];
      tx_st = {tx_st[56:0], o[i]};
    end
    return o;
  endfunction

  // Receive reference: out[n] = x[n] ^ x[n-39] ^ x[n-58] over the received stream.
  function automatic logic [DW-1:0] rx_model(input logic [DW-1:0] x);
    logic [DW-1:0] o;
    for (int i = 0; i < DW; i++) begin
      o[i]    = x[i] ^ rx_hist[38] ^ rx_hist[57];
      rx_hist = {rx_hist[56:0], x[i]};
    end
    return o;
  endfunction

  task automatic step(input bit rstn, input bit v, input logic [DW-1:0] d_in, input bit hv,
                      input logic [1:0] h, input bit lk, input logic [DW-1:0] plain);
    exp_t e;
    reset_n = rstn; data_valid = v; data = d_in; hdr_valid = hv; hdr = h; block_lock = lk;
    if (!rstn) begin
      sb.delete();
      rx_hist = '1;
      cnt     = 0;
    end else begin
      if (v) begin
        e.dmodel   = rx_model(d_in);
        e.plain    = plain;
        e.sy       = lk && (cnt >= WW);
        e.plain_ok = loopback && e.sy;
        e.hv       = hv;
        e.h        = h;
        e.he       = hv && (h[1] == h[0]);
        sb.push_back(e);
      end
      if (!lk) cnt = 0;
      else if (v && cnt < WW) cnt++;
    end
    @(posedge clk);
    #1;
    if (!rstn) begin
      chk("rst_data_valid", o_data_valid, 0);
      chk("rst_data", o_data, 0);
      chk("rst_hdr_valid", o_hdr_valid, 0);
      chk("rst_hdr", o_hdr, 0);
      chk("rst_hdr_err", o_hdr_err, 0);
      chk("rst_synced", o_synced, 0);
      last_data = '0;
    end else begin
      chk("valid_latency", o_data_valid, v);
      if (v) begin
        if (sb.size() == 0) begin
          chk("scoreboard_empty", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("data_model", o_data, e.dmodel);
          if (e.plain_ok) chk("data_plain", o_data, e.plain);
          chk("hdr_valid", o_hdr_valid, e.hv);
          if (e.hv) chk("hdr", o_hdr, e.h);
          chk("hdr_err", o_hdr_err, e.he);
          chk("synced", o_synced, e.sy);
        end
        last_data = o_data;
      end else begin
        chk("hdr_valid_idle", o_hdr_valid, 0);
        chk("data_hold", o_data, last_data);
      end
    end
  endtask

  // One loopback cycle: random plaintext through the TX scrambler into the DUT.
  task automatic lb(input bit v, input bit hv, input logic [1:0] h, input bit lk);
    logic [DW-1:0] p;
    logic [DW-1:0] s;
    p = $urandom;
    if (v) s = tx_scramble(p);
    else   s = $urandom;
    step(1'b1, v, s, hv && v, h, lk, p);
  endtask

  initial begin
    logic [DW-1:0] zexp [3];
    int            zsy  [3];
    logic [1:0]    hseq [4];
    int            eseq [4];
    int            pos;
    bit            v;
    zexp = '{32'h00000000, 32'h03FFFF80, 32'h00000000};
    zsy  = '{0, 0, 1};
    hseq = '{2'b01, 2'b10, 2'b11, 2'b00};
    eseq = '{0, 0, 1, 1};
    reset_n = 1'b0; data_valid = 1'b0; data = '0; hdr_valid = 1'b0; hdr = 2'b00;
    block_lock = 1'b0; loopback = 1'b0; tx_st = '1; rx_hist = '1; cnt = 0; last_data = '0;

    step(1'b0, 1'b0, '0, 1'b0, 2'b00, 1'b0, '0);
    step(1'b0, 1'b0, '0, 1'b0, 2'b00, 1'b1, '0);

    // Zero stream straight out of reset with lock already high.
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 1'b1, '0, 1'b0, 2'b00, 1'b1, '0);
      chk("zero_word", o_data, zexp[k]);
      chk("zero_synced", o_synced, zsy[k]);
    end

    // Fresh start for loopback so TX and RX LFSRs begin identical.
    step(1'b0, 1'b0, '0, 1'b0, 2'b00, 1'b1, '0);
    tx_st = '1;
    loopback = 1'b1;

    // Header pass-through: two-word blocks, header on the first word.
    for (int k = 0; k < 4; k++) begin
      lb(1'b1, 1'b1, hseq[k], 1'b1);
      chk("hdr_seq", o_hdr, hseq[k]);
      chk("hdr_err_seq", o_hdr_err, eseq[k]);
      lb(1'b1, 1'b0, 2'b00, 1'b1);
    end

    // A header strobe without data must be ignored.
    step(1'b1, 1'b0, 32'hDEADBEEF, 1'b1, 2'b11, 1'b1, '0);
    chk("hdr_without_data", o_hdr_err, 0);

    // Long random loopback with random gaps.
    pos = 0;
    for (int i = 0; i < 1000; i++) begin
      v = ($urandom_range(0, 3) != 0);
      lb(v, pos == 0, ($urandom_range(0, 1) != 0) ? SYNC_DATA : SYNC_CTRL, 1'b1);
      if (v) pos = (pos + 1) % 2;
    end

    // Lock drop for one cycle while synced, then regain with continuous words.
    lb(1'b1, 1'b0, 2'b00, 1'b0);
    chk("drop_synced", o_synced, 0);
    for (int k = 0; k < 3; k++) begin
      lb(1'b1, 1'b0, 2'b00, 1'b1);
      chk("regain_synced", o_synced, zsy[k]);
    end
    for (int i = 0; i < 10; i++) lb(1'b1, 1'b0, 2'b00, 1'b1);

    // Strictly alternating valid/idle cycles.
    for (int i = 0; i < 16; i++) lb(i % 2 == 0, i % 4 == 0, SYNC_DATA, 1'b1);

    // Mid-stream reset with a word in flight; that word is lost to the DUT.
    lb(1'b1, 1'b0, 2'b00, 1'b1);
    begin
      logic [DW-1:0] p;
      logic [DW-1:0] s;
      p = $urandom;
      s = tx_scramble(p);
      step(1'b0, 1'b1, s, 1'b1, SYNC_CTRL, 1'b1, p);
    end
    for (int k = 0; k < 3; k++) begin
      lb(1'b1, 1'b0, 2'b00, 1'b1);
      chk("post_reset_synced", o_synced, zsy[k]);
    end
    for (int i = 0; i < 20; i++) lb($urandom_range(0, 1) != 0, 1'b0, 2'b00, 1'b1);

    chk("scoreboard_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
